// File: rtl/evg_event_pkg.sv
// rtl/evg_event_pkg.sv - shared event-code definitions for the EVG transmit path
// Contents: EVENT_CODE_WIDTH, EVENT_NULL, EVENT_HEARTBEAT, event_code_t, grant_e.
package evg_event_pkg;

  localparam int EVENT_CODE_WIDTH = 8;

  typedef logic [EVENT_CODE_WIDTH-1:0] event_code_t;

  localparam event_code_t EVENT_NULL      = 8'h00;
  localparam event_code_t EVENT_HEARTBEAT = 8'h7A;

  // Owner of the transmit slot in a given cycle.
  typedef enum logic [1:0] {
    GRANT_NULL,
    GRANT_SEQ,
    GRANT_HB,
    GRANT_SW
  } grant_e;

endpackage

// File: rtl/heartbeat_event_inserter_if.sv
// rtl/heartbeat_event_inserter_if.sv - event request/response bundle for the heartbeat inserter
// slave : inserter side (requests in, transmit code and statistics out)
// master: driver side (requests out, transmit code and statistics in)
interface heartbeat_event_inserter_if;
  import evg_event_pkg::*;

  logic        txHeartbeatStrobe;
  event_code_t seqEventCode;
  logic        seqEventValid;
  event_code_t swEventCode;
  logic        swEventStrobe;
  logic        clearStats;
  event_code_t txEventCode;
  logic        heartbeatSent;
  logic        swEventBusy;
  logic [15:0] hbDropCount;
  logic [7:0]  hbMaxLatency;
  logic        heartbeatMissing;

  modport slave (
    input  txHeartbeatStrobe, seqEventCode, seqEventValid,
    input  swEventCode, swEventStrobe, clearStats,
    output txEventCode, heartbeatSent, swEventBusy,
    output hbDropCount, hbMaxLatency, heartbeatMissing
  );

  modport master (
    output txHeartbeatStrobe, seqEventCode, seqEventValid,
    output swEventCode, swEventStrobe, clearStats,
    input  txEventCode, heartbeatSent, swEventBusy,
    input  hbDropCount, hbMaxLatency, heartbeatMissing
  );

endinterface

// File: rtl/heartbeat_event_inserter_sat_counter.sv
// rtl/heartbeat_event_inserter_sat_counter.sv - saturating up-counter (module sat_counter)
// Ports: clk, rst (async, active-high), clear (forces zero, wins over all),
//        restart (starts a new count that includes this cycle's inc), inc, count.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             restart,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (restart) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && count != COUNT_MAX) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/heartbeat_event_inserter.sv
// rtl/heartbeat_event_inserter.sv - merges heartbeat, sequencer and software events into one tx slot
// Ports: txClk, txReset (async, active-high), ev (heartbeat_event_inserter_if.slave).
// Slot priority: sequencer > heartbeat > software > null; txEventCode is registered.
module heartbeat_event_inserter
  import evg_event_pkg::*;
#(
  parameter event_code_t HEARTBEAT_CODE       = EVENT_HEARTBEAT,
  parameter int          TX_CLK_PER_HEARTBEAT = -1,
  parameter int          WATCHDOG_MARGIN      = 16
) (
  input  logic                     txClk,
  input  logic                     txReset,
  heartbeat_event_inserter_if.slave ev
);

  localparam int WD_RELOAD = TX_CLK_PER_HEARTBEAT + WATCHDOG_MARGIN - 1;
  localparam int WD_W      = (WD_RELOAD > 1) ? $clog2(WD_RELOAD + 1) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WD_RELOAD);

  grant_e      grant;
  event_code_t grant_code;
  logic        hb_pending, sw_pending, sw_emit;
  event_code_t sw_code;
  logic [7:0]  lat_count, hb_max;
  logic [WD_W-1:0] wd_count;

  logic seq_win, hb_req, hb_grant, sw_grant;
  logic hb_fresh, hb_reset_again, hb_drop, sw_accept;
  logic [7:0] lat_now;

  // A strobe is grantable in its own cycle, so the heartbeat request is the
  // pending flag OR the live strobe.
  assign seq_win  = ev.seqEventValid && (ev.seqEventCode != EVENT_NULL);
  assign hb_req   = hb_pending || ev.txHeartbeatStrobe;
  assign hb_grant = (grant == GRANT_HB);
  assign sw_grant = (grant == GRANT_SW);

  assign hb_fresh       = ev.txHeartbeatStrobe && !hb_pending;
  assign hb_reset_again = ev.txHeartbeatStrobe && hb_pending && hb_grant;
  assign hb_drop        = ev.txHeartbeatStrobe && hb_pending && !hb_grant;
  assign lat_now        = hb_fresh ? 8'd0 : lat_count;

  // Busy covers the pending cycles plus the cycle the code is on txEventCode.
  assign ev.swEventBusy = sw_pending || sw_emit;
  assign sw_accept      = ev.swEventStrobe && (ev.swEventCode != EVENT_NULL) && !ev.swEventBusy;

  always_comb begin
    grant      = GRANT_NULL;
    grant_code = EVENT_NULL;
    if (seq_win) begin
      grant      = GRANT_SEQ;
      grant_code = ev.seqEventCode;
    end else if (hb_req) begin
      grant      = GRANT_HB;
      grant_code = HEARTBEAT_CODE;
    end else if (sw_pending) begin
      grant      = GRANT_SW;
      grant_code = sw_code;
    end
  end

  always_ff @(posedge txClk or posedge txReset) begin
    if (txReset) begin
      ev.txEventCode   <= EVENT_NULL;
      ev.heartbeatSent <= 1'b0;
      hb_pending       <= 1'b0;
      sw_pending       <= 1'b0;
      sw_emit          <= 1'b0;
      sw_code          <= EVENT_NULL;
      hb_max           <= 8'd0;
    end else begin
      ev.txEventCode   <= grant_code;
      ev.heartbeatSent <= hb_grant;
      // A strobe coinciding with the grant of the previous heartbeat re-arms it.
      hb_pending       <= hb_grant ? hb_reset_again : hb_req;
      sw_emit          <= sw_grant;
      if (sw_grant) begin
        sw_pending <= 1'b0;
      end else if (sw_accept) begin
        sw_pending <= 1'b1;
        sw_code    <= ev.swEventCode;
      end
      if (ev.clearStats) begin
        hb_max <= 8'd0;
      end else if (hb_grant && lat_now > hb_max) begin
        hb_max <= lat_now;
      end
    end
  end

  always_ff @(posedge txClk or posedge txReset) begin
    if (txReset) begin
      wd_count            <= WD_LOAD;
      ev.heartbeatMissing <= 1'b0;
    end else if (ev.txHeartbeatStrobe) begin
      wd_count            <= WD_LOAD;
      ev.heartbeatMissing <= 1'b0;
    end else begin
      if (wd_count != '0) begin
        wd_count <= wd_count - WD_W'(1);
      end
      if (wd_count == WD_W'(1)) begin
        ev.heartbeatMissing <= 1'b1;
      end
    end
  end

  assign ev.hbMaxLatency = hb_max;

  sat_counter #(.WIDTH(16)) u_drop_count (
    .clk     (txClk),
    .rst     (txReset),
    .clear   (ev.clearStats),
    .restart (1'b0),
    .inc     (hb_drop),
    .count   (ev.hbDropCount)
  );

  // Counts cycles the current heartbeat has waited behind the sequencer.
  sat_counter #(.WIDTH(8)) u_latency (
    .clk     (txClk),
    .rst     (txReset),
    .clear   (1'b0),
    .restart (hb_fresh || hb_reset_again),
    .inc     (hb_req && !hb_grant),
    .count   (lat_count)
  );

endmodule

// File: doc/heartbeat_event_inserter.md
HEARTBEAT_EVENT_INSERTER -- requirements
Module: heartbeat_event_inserter

Interface
REQ-001 The block SHALL have a single clock and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter HEARTBEAT_CODE, default 8'h7A, is the event code emitted for each heartbeat.
REQ-003 Parameter TX_CLK_PER_HEARTBEAT, default -1 (must be overridden), is the nominal heartbeat period in txClk cycles.
REQ-004 Parameter WATCHDOG_MARGIN, default 16, is the extra txClk cycles tolerated before a heartbeat is declared missing.
REQ-005 txClk  in  1  transmitter (EVG) clock; all logic in this domain.
REQ-006 txReset  in  1  asynchronous active-high reset.
REQ-007 txHeartbeatStrobe  in  1  single-cycle heartbeat request from the coincidence recorder.
REQ-008 seqEventCode  in  8  sequencer event code; seqEventValid  in  1  qualifies it.
REQ-009 swEventCode  in  8  software event code; swEventStrobe  in  1  single-cycle software request.
REQ-010 clearStats  in  1  single-cycle clear of statistics.
REQ-011 txEventCode  out  8  registered event code to the transmitter; 8'h00 = null.
REQ-012 heartbeatSent  out  1  one-cycle pulse, aligned with HEARTBEAT_CODE on txEventCode.
REQ-013 swEventBusy  out  1  software request pending.
REQ-014 hbDropCount  out  16  saturating count of heartbeat requests lost to overlap.
REQ-015 hbMaxLatency  out  8  saturating maximum heartbeat blocking delay, in cycles.
REQ-016 heartbeatMissing  out  1  sticky watchdog flag.

Function
REQ-017 Each cycle one slot SHALL be granted: priority sequencer > pending heartbeat > pending software > null.
REQ-018 Sequencer wins only when seqEventValid=1 and seqEventCode!=0; it is never delayed; code equal to HEARTBEAT_CODE passes unchanged and does not clear heartbeat pending.
REQ-019 txEventCode SHALL present the granted code one cycle after the grant (latency 1 from request when unblocked).
REQ-020 txHeartbeatStrobe SHALL set hbPending; hbPending clears when the heartbeat is granted.
REQ-021 Strobe while hbPending=1 and not granted this cycle: hbDropCount+1 (saturate 16'hFFFF), hbPending stays 1.
REQ-022 Strobe in the same cycle the pending heartbeat is granted: hbPending stays 1, no drop counted.
REQ-023 Blocking-latency counter: cleared on set of hbPending, +1 per cycle heartbeat is blocked (saturate 255); on grant hbMaxLatency = max(hbMaxLatency, counter).
REQ-024 swEventStrobe with swEventCode!=0 and swEventBusy=0 SHALL latch the code and set swEventBusy; otherwise it is ignored; swEventBusy clears on grant.
REQ-025 Watchdog loads TX_CLK_PER_HEARTBEAT+WATCHDOG_MARGIN-1 on each strobe and decrements otherwise; on reaching 0 heartbeatMissing=1 until the next strobe (cleared the cycle after the strobe).
REQ-026 clearStats SHALL zero hbDropCount and hbMaxLatency; simultaneous increment and clear results in 0.

Reset
REQ-027 On txReset: txEventCode=0, heartbeatSent=0, swEventBusy=0, hbPending=0, hbDropCount=0, hbMaxLatency=0, heartbeatMissing=0, watchdog loaded with full reload.
REQ-028 Reset mid-operation SHALL discard pending heartbeat and software requests without emitting them.

Structure
REQ-029 Shared package evg_event_pkg SHALL hold EVENT_CODE_WIDTH=8, EVENT_NULL=8'h00, EVENT_HEARTBEAT=8'h7A.
REQ-030 One sub-module sat_counter (parameterised width, increment, clear, saturation) SHALL be used for hbDropCount and the latency counter.

Verification (TX_CLK_PER_HEARTBEAT=100, WATCHDOG_MARGIN=16)
REQ-031 Idle, strobe at cycle 10 -> txEventCode=8'h7A and heartbeatSent=1 at cycle 11 only; hbMaxLatency=0.
REQ-032 seqEventValid=1 code 8'h01 on cycles 10-14, strobe at 10 -> 8'h01 on cycles 11-15, 8'h7A on cycle 16, hbMaxLatency=5.
REQ-033 Sequencer busy cycles 10-20, strobes at 10 and 15 -> one heartbeat emitted, hbDropCount=1; clearStats -> 0.
REQ-034 swEventStrobe code 8'h55 at cycle 10 and 8'h66 at 11, strobe at 10 -> 8'h7A at 11, 8'h55 at 12, 8'h66 never; swEventBusy 1 on cycles 11-12.
REQ-035 Strobes stop after cycle 0 -> heartbeatMissing rises at cycle 116; strobe at 200 -> cleared by 201.
REQ-036 txReset asserted at cycle 12 with heartbeat and software pending -> all outputs 0 immediately, nothing emitted after release.
